// File: rtl/lbp_host.sv
// Host-side buffer for an LBP engine: clears the result memory, loads a gray image,
// serves pixel reads / result writes, then streams every result back in address order.
module lbp_host #(
  parameter int unsigned AW = 14,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          gray_ready,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic [DW-1:0] gray_data,
  input  logic          lbp_valid,
  input  logic [AW-1:0] lbp_addr,
  input  logic [DW-1:0] lbp_data,
  input  logic          finish,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          done
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [AW:0] LAST  = (AW+1)'(DEPTH - 1);

  typedef enum logic [2:0] {S_CLEAR, S_LOAD, S_SERVE, S_DRAIN, S_DONE} state_t;

  logic [DW-1:0] gray_mem [DEPTH];
  logic [DW-1:0] lbp_mem  [DEPTH];

  state_t        state, state_d;
  logic [AW:0]   cnt, cnt_d;
  logic          rd_valid_d, rd_last_d;
  logic [AW-1:0] rd_addr_d;
  logic          gray_we_c, lbp_we_c, gray_rd_c, beat_ld_c;
  logic [AW-1:0] lbp_wa_c;
  logic [DW-1:0] lbp_wd_c;

  // Next-state, counter and memory-strobe decode
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    rd_valid_d = rd_valid;
    rd_addr_d  = rd_addr;
    rd_last_d  = rd_last;
    gray_we_c  = 1'b0;
    lbp_we_c   = 1'b0;
    lbp_wa_c   = cnt[AW-1:0];
    lbp_wd_c   = '0;
    gray_rd_c  = 1'b0;
    beat_ld_c  = 1'b0;
    unique case (state)
      S_CLEAR: begin
        lbp_we_c = 1'b1;
        if (cnt == LAST) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + (AW+1)'(1);
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          gray_we_c = 1'b1;
          if (cnt == LAST) begin
            state_d = S_SERVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + (AW+1)'(1);
          end
        end
      end
      S_SERVE: begin
        gray_rd_c = gray_req;
        if (lbp_valid) begin
          lbp_we_c = 1'b1;
          lbp_wa_c = lbp_addr;
          lbp_wd_c = lbp_data;
        end
        if (finish) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        // Output register is free when empty or being accepted this cycle
        if (!rd_valid || rd_ready) begin
          if (rd_valid && rd_last) begin
            state_d    = S_DONE;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
          end else if (!cnt[AW]) begin
            beat_ld_c  = 1'b1;
            rd_valid_d = 1'b1;
            rd_addr_d  = cnt[AW-1:0];
            rd_last_d  = (cnt == LAST);
            cnt_d      = cnt + (AW+1)'(1);
          end else begin
            rd_valid_d = 1'b0;
          end
        end
      end
      S_DONE: begin
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_CLEAR;
      cnt        <= '0;
      ld_ready   <= 1'b0;
      gray_ready <= 1'b0;
      gray_data  <= '0;
      rd_valid   <= 1'b0;
      rd_addr    <= '0;
      rd_data    <= '0;
      rd_last    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      ld_ready   <= (state_d == S_LOAD);
      gray_ready <= (state_d == S_SERVE);
      done       <= (state_d == S_DONE);
      rd_valid   <= rd_valid_d;
      rd_addr    <= rd_addr_d;
      rd_last    <= rd_last_d;
      gray_data  <= gray_rd_c ? gray_mem[gray_addr] : '0;
      if (beat_ld_c) rd_data <= lbp_mem[cnt[AW-1:0]];
    end
  end

  // Memory writes; nothing commits on a reset edge
  always_ff @(posedge clk) begin
    if (reset && gray_we_c) gray_mem[cnt[AW-1:0]] <= ld_data;
    if (reset && lbp_we_c)  lbp_mem[lbp_wa_c]     <= lbp_wd_c;
  end

endmodule

// File: tb/tb_lbp_host.sv
// Bench for lbp_host: transaction-level model (counts of clears/loads/beats plus
// image and result arrays) checked every cycle, plus directed literal expectations.
module tb_lbp_host;
  localparam int unsigned AW = 14;
  localparam int unsigned DW = 8;
  localparam int N = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [DW-1:0] gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [DW-1:0] lbp_data;
  logic          finish;
  logic          rd_ready;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          done;

  lbp_host #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .gray_ready(gray_ready), .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_last(rd_last), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: progress counters and memory images
  bit        model_on = 1'b0;
  int        clears, loaded, beats;
  bit        finished;
  logic [7:0] gray_m [N];
  logic [7:0] lbp_m  [N];
  logic [7:0] gray_exp;

  always @(posedge clk) begin
    if (!reset) begin
      model_on = 1'b1;
      clears   = 0;
      loaded   = 0;
      beats    = 0;
      finished = 1'b0;
      gray_exp = 8'h00;
      for (int k = 0; k < N; k++) lbp_m[k] = 8'h00;
    end else if (model_on) begin
      gray_exp = 8'h00;
      if (clears < N) begin
        clears++;
      end else if (loaded < N) begin
        if (ld_valid) begin
          gray_m[loaded] = ld_data;
          loaded++;
        end
      end else if (!finished) begin
        if (gray_req)  gray_exp = gray_m[gray_addr];
        if (lbp_valid) lbp_m[lbp_addr] = lbp_data;
        if (finish)    finished = 1'b1;
      end else if (beats < N) begin
        if (rd_valid && rd_ready) beats++;
      end
    end
  end

  // Per-cycle compare against the model
  logic          prev_v, prev_r, prev_l;
  logic [AW-1:0] prev_a;
  logic [DW-1:0] prev_d;
  int            drain_idle;
  int            last_cnt = 0;

  always @(negedge clk) begin
    if (model_on) begin
      bit drain;
      drain = (loaded == N) && finished && (beats < N);
      check("ld_ready",   32'(ld_ready),   32'((clears == N) && (loaded < N)));
      check("gray_ready", 32'(gray_ready), 32'((loaded == N) && !finished));
      check("gray_data",  32'(gray_data),  32'(gray_exp));
      check("done",       32'(done),       32'(beats == N));
      if (!reset) begin
        drain_idle = 0;
        prev_v     = 1'b0;
        prev_r     = 1'b0;
      end
      if (reset && prev_v && !prev_r) begin
        check("stall_valid", 32'(rd_valid), 32'(prev_v));
        check("stall_addr",  32'(rd_addr),  32'(prev_a));
        check("stall_data",  32'(rd_data),  32'(prev_d));
        check("stall_last",  32'(rd_last),  32'(prev_l));
      end
      if (rd_valid) begin
        check("rd_valid_in_drain", 32'(drain), 32'(1));
        check("rd_addr", 32'(rd_addr), 32'(beats));
        check("rd_data", 32'(rd_data), 32'(lbp_m[beats % N]));
        check("rd_last", 32'(rd_last), 32'(beats == N - 1));
        if (rd_ready) begin
          if (rd_last) last_cnt++;
          case (rd_addr)
            14'h0081: check("rb_0081", 32'(rd_data), 32'h3C);
            14'h000A: check("rb_000a", 32'(rd_data), 32'h00);
            14'h0014: check("rb_0014", 32'(rd_data), 32'h00);
            14'h0000: check("rb_0000", 32'(rd_data), 32'h11);
            14'h3FFF: check("rb_3fff", 32'(rd_data), 32'h42);
            default: ;
          endcase
        end
      end else if (drain) begin
        drain_idle++;
        check("drain_gap", 32'(drain_idle <= 2), 32'(1));
      end
      prev_v = rd_valid;
      prev_r = rd_ready;
      prev_a = rd_addr;
      prev_d = rd_data;
      prev_l = rd_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear();
    for (int k = 1; k <= N; k++) begin
      step();
      if (k == N - 1) check("ld_ready_clear_end", 32'(ld_ready), 32'(0));
      if (k == N) begin
        check("ld_ready_load_start", 32'(ld_ready), 32'(1));
        check("gray_ready_load_start", 32'(gray_ready), 32'(0));
      end
    end
  endtask

  task automatic load_image(input bit gaps, input bit invert);
    int i = 0;
    int c = 0;
    while (i < N) begin
      if (gaps && (c % 3 == 2)) begin
        ld_valid = 1'b0;
      end else begin
        ld_valid = 1'b1;
        ld_data  = invert ? ~8'(i) : 8'(i);
        i++;
      end
      c++;
      step();
    end
    ld_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; ld_valid = 1'b0; ld_data = '0; gray_req = 1'b0; gray_addr = '0;
    lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0; finish = 1'b0; rd_ready = 1'b0;
    repeat (3) step();
    check("rst_ld_ready",   32'(ld_ready),   32'(0));
    check("rst_gray_ready", 32'(gray_ready), 32'(0));
    check("rst_gray_data",  32'(gray_data),  32'(0));
    check("rst_rd_valid",   32'(rd_valid),   32'(0));
    check("rst_rd_addr",    32'(rd_addr),    32'(0));
    check("rst_rd_data",    32'(rd_data),    32'(0));
    check("rst_rd_last",    32'(rd_last),    32'(0));
    check("rst_done",       32'(done),       32'(0));

    // Run 1: full-rate inverted image, one result write, then reset from SERVE
    reset = 1'b1; ld_valid = 1'b1; ld_data = 8'hEE;
    wait_clear();
    load_image(1'b0, 1'b1);
    check("r1_gray_ready", 32'(gray_ready), 32'(1));
    gray_req = 1'b1; gray_addr = 14'h0081;
    step();
    check("r1_gray_0081", 32'(gray_data), 32'h7E);
    gray_req = 1'b0; lbp_valid = 1'b1; lbp_addr = 14'd10; lbp_data = 8'hFF;
    step();
    reset = 1'b0; gray_req = 1'b1; gray_addr = 14'h0081;
    step();
    check("midrst_gray_data",  32'(gray_data),  32'(0));
    check("midrst_gray_ready", 32'(gray_ready), 32'(0));
    check("midrst_ld_ready",   32'(ld_ready),   32'(0));
    check("midrst_rd_valid",   32'(rd_valid),   32'(0));
    check("midrst_done",       32'(done),       32'(0));

    // Run 2: gapped load with finish/lbp_valid/gray_req asserted outside SERVE
    reset = 1'b1; lbp_valid = 1'b1; lbp_addr = 14'd20; lbp_data = 8'h77;
    finish = 1'b1; gray_req = 1'b1; gray_addr = 14'd3;
    wait_clear();
    load_image(1'b1, 1'b0);
    lbp_valid = 1'b0; finish = 1'b0; gray_req = 1'b0;
    check("r2_gray_ready", 32'(gray_ready), 32'(1));
    gray_req = 1'b1; gray_addr = 14'h0081;
    step();
    check("gray_0081", 32'(gray_data), 32'h81);
    gray_addr = 14'd5;
    step();
    check("gray_0005", 32'(gray_data), 32'h05);
    gray_addr = 14'd6;
    step();
    check("gray_0006", 32'(gray_data), 32'h06);
    gray_req = 1'b0;
    step();
    check("gray_idle", 32'(gray_data), 32'h00);
    lbp_valid = 1'b1; lbp_addr = 14'h0000; lbp_data = 8'h11;
    step();
    lbp_addr = 14'h3FFF; lbp_data = 8'h42;
    step();
    lbp_addr = 14'h0081; lbp_data = 8'hA5;
    step();
    lbp_data = 8'h3C; finish = 1'b1;
    step();
    lbp_valid = 1'b0; finish = 1'b0;
    check("drain_gray_ready", 32'(gray_ready), 32'(0));

    // Drain: stall-toggled near both ends, full rate in between
    begin
      int  cyc = 0;
      bit  tog = 1'b1;
      while (!done && cyc < 20000) begin
        rd_ready = (rd_addr < 14'd256 || rd_addr >= 14'(N - 256)) ? tog : 1'b1;
        tog = ~tog;
        step();
        cyc++;
      end
      check("drain_timeout", 32'(done), 32'(1));
    end
    rd_ready = 1'b1;
    repeat (4) step();
    check("end_beats",    32'(beats),    32'(N));
    check("end_last_cnt", 32'(last_cnt), 32'(1));
    check("end_done",     32'(done),     32'(1));
    check("end_rd_valid", 32'(rd_valid), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
